cpu_exec_unit: RTL and testbench



---
 rtl/cpu_exec_unit_pkg.sv | 32 +++
 rtl/cpu_exec_unit_if.sv | 35 +++
 rtl/cpu_exec_unit_opcode_decoder.sv | 48 ++++
 rtl/cpu_exec_unit.sv | 69 ++++++
 tb/tb_cpu_exec_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/cpu_exec_unit_pkg.sv
// Purpose: shared constants and types for the CPU execute stage.
//   - opcode encodings (NOP..WAIT)
//   - operand-enable bit indices
//   - decoded control bundle type produced by the opcode decoder
package cpu_exec_unit_pkg;

  localparam int OPC_W = 3;
  localparam int EN_W  = 5;

  localparam logic [OPC_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OPC_W-1:0] OP_LDI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_MOV  = 3'b010;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b011;
  localparam logic [OPC_W-1:0] OP_ADDI = 3'b100;
  localparam logic [OPC_W-1:0] OP_OUT  = 3'b101;
  localparam logic [OPC_W-1:0] OP_CLR  = 3'b110;
  localparam logic [OPC_W-1:0] OP_WAIT = 3'b111;

  // Operand-enable bit positions
  localparam int EN_A_RD  = 0;  // A <= rd_data_a
  localparam int EN_A_IMM = 1;  // A <= imm
  localparam int EN_B_RD  = 2;  // B <= rd_data_b
  localparam int EN_B_IMM = 3;  // B <= imm
  localparam int EN_CLR   = 4;  // A <= 0, B <= 0

  typedef struct packed {
    logic            f_add;
    logic            wr_res;
    logic [EN_W-1:0] en;
  } dec_t;

endpackage

// File: rtl/cpu_exec_unit_if.sv
// Purpose: groups the execute-stage data, control and handshake signals.
//   slave  modport : execute unit (consumes decode/operand inputs, drives results)
//   master modport : surrounding CPU / testbench
// Signals:
//   opcode, rd_data_a, rd_data_b, imm         -> execute inputs
//   fetch_opcode, wait_sel, wait_pol, ready_in -> WAIT / PC-enable inputs
//   result, wr_res, pc_en, pattern_match       <- execute outputs
interface cpu_exec_unit_if #(
  parameter int BUS_WIDTH = 8
);
  logic [2:0]           opcode;
  logic [BUS_WIDTH-1:0] rd_data_a;
  logic [BUS_WIDTH-1:0] rd_data_b;
  logic [BUS_WIDTH-1:0] imm;
  logic [2:0]           fetch_opcode;
  logic                 wait_sel;
  logic                 wait_pol;
  logic                 ready_in;
  logic [BUS_WIDTH-1:0] result;
  logic                 wr_res;
  logic                 pc_en;
  logic                 pattern_match;

  modport slave (
    input  opcode, rd_data_a, rd_data_b, imm,
    input  fetch_opcode, wait_sel, wait_pol, ready_in,
    output result, wr_res, pc_en, pattern_match
  );

  modport master (
    output opcode, rd_data_a, rd_data_b, imm,
    output fetch_opcode, wait_sel, wait_pol, ready_in,
    input  result, wr_res, pc_en, pattern_match
  );
endinterface

// File: rtl/cpu_exec_unit_opcode_decoder.sv
// Purpose: pure combinational opcode decoder for the execute stage.
// Ports:
//   i_opcode  in  3  registered opcode
//   o_dec     out    {f_add, wr_res, en[4:0]} control bundle
module cpu_opcode_decoder
  import cpu_exec_unit_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_LDI: begin
        o_dec.en[EN_B_IMM] = 1'b1;
        o_dec.wr_res       = 1'b1;
      end
      OP_MOV: begin
        o_dec.en[EN_B_RD] = 1'b1;
        o_dec.wr_res      = 1'b1;
      end
      OP_ADD: begin
        o_dec.en[EN_A_RD] = 1'b1;
        o_dec.en[EN_B_RD] = 1'b1;
        o_dec.f_add       = 1'b1;
        o_dec.wr_res      = 1'b1;
      end
      OP_ADDI: begin
        o_dec.en[EN_A_RD]  = 1'b1;
        o_dec.en[EN_B_IMM] = 1'b1;
        o_dec.f_add        = 1'b1;
        o_dec.wr_res       = 1'b1;
      end
      OP_OUT: begin
        o_dec.en[EN_B_RD] = 1'b1;
      end
      OP_CLR: begin
        // f_add with both operands cleared yields 0 on the adder path
        o_dec.en[EN_CLR] = 1'b1;
        o_dec.f_add      = 1'b1;
        o_dec.wr_res     = 1'b1;
      end
      default: o_dec = '0;  // NOP, WAIT
    endcase
  end

endmodule

// File: rtl/cpu_exec_unit.sv
// Purpose: execute stage of the 8-bit CPU. Latches ALU operands per the
//   decoded opcode, produces the register write data/request and the
//   WAIT-based program-counter enable from the ready_in handshake.
// Ports:
//   clk      in  system clock, rising edge
//   n_reset  in  asynchronous active-low reset
//   bus      cpu_exec_unit_if.slave (see interface header for signal list)
module cpu_exec_unit
  import cpu_exec_unit_pkg::*;
#(
  parameter int BUS_WIDTH    = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input logic            clk,
  input logic            n_reset,
  cpu_exec_unit_if.slave bus
);

  logic [BUS_WIDTH-1:0]    r_opa;
  logic [BUS_WIDTH-1:0]    r_opb;
  logic                    r_f_add_q;
  logic                    r_ready_p;
  dec_t                    w_dec;
  logic [OPCODE_WIDTH-1:0] w_fetch_opcode;
  logic                    w_cond;

  // Modular add: carry out is intentionally dropped
  function automatic logic [BUS_WIDTH-1:0] add_wrap(input logic [BUS_WIDTH-1:0] a,
                                                    input logic [BUS_WIDTH-1:0] b);
    return a + b;
  endfunction

  cpu_opcode_decoder u_dec (
    .i_opcode (bus.opcode),
    .o_dec    (w_dec)
  );

  // Operand / control register stage
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_opa     <= '0;
      r_opb     <= '0;
      r_f_add_q <= 1'b0;
      r_ready_p <= 1'b0;
    end else begin
      r_f_add_q <= w_dec.f_add;
      r_ready_p <= bus.ready_in;
      if (w_dec.en[EN_CLR]) begin
        r_opa <= '0;
        r_opb <= '0;
      end else begin
        // Immediate source wins over register source for the same operand
        if (w_dec.en[EN_A_IMM])     r_opa <= bus.imm;
        else if (w_dec.en[EN_A_RD]) r_opa <= bus.rd_data_a;
        if (w_dec.en[EN_B_IMM])     r_opb <= bus.imm;
        else if (w_dec.en[EN_B_RD]) r_opb <= bus.rd_data_b;
      end
    end
  end

  // Output / PC-enable logic
  assign w_fetch_opcode    = bus.fetch_opcode;
  assign bus.result        = r_f_add_q ? add_wrap(r_opa, r_opb) : r_opb;
  assign bus.wr_res        = w_dec.wr_res;
  assign bus.pattern_match = ~r_ready_p & bus.ready_in;
  assign w_cond            = bus.wait_sel ? bus.pattern_match : bus.ready_in;
  assign bus.pc_en         = (w_fetch_opcode != OP_WAIT) | (w_cond == bus.wait_pol);

endmodule

// File: tb/tb_cpu_exec_unit.sv
module tb_cpu_exec_unit;
  logic clk = 1'b0;
  logic n_reset;
  int   tests = 0;
  int   fails = 0;

  cpu_exec_unit_if #(.BUS_WIDTH(8)) bus ();

  cpu_exec_unit #(.BUS_WIDTH(8), .OPCODE_WIDTH(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state: the two operands, whether last op was an add,
  // and the previous ready_in sample.
  logic [7:0] m_a, m_b;
  logic       m_add, m_prev;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_a = 8'h00; m_b = 8'h00; m_add = 1'b0; m_prev = 1'b0;
    end else begin
      case (bus.opcode)
        3'd1: begin m_b = bus.imm;                           m_add = 1'b0; end
        3'd2: begin m_b = bus.rd_data_b;                     m_add = 1'b0; end
        3'd3: begin m_a = bus.rd_data_a; m_b = bus.rd_data_b; m_add = 1'b1; end
        3'd4: begin m_a = bus.rd_data_a; m_b = bus.imm;       m_add = 1'b1; end
        3'd5: begin m_b = bus.rd_data_b;                     m_add = 1'b0; end
        3'd6: begin m_a = 8'h00; m_b = 8'h00;                m_add = 1'b1; end
        default:                                              m_add = 1'b0;
      endcase
      m_prev = bus.ready_in;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [7:0] e_res;
    logic       e_wr, e_pm, e_cond, e_pc;
    e_res  = m_add ? 8'(m_a + m_b) : m_b;
    e_wr   = (bus.opcode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6});
    e_pm   = !m_prev && bus.ready_in;
    e_cond = bus.wait_sel ? e_pm : bus.ready_in;
    e_pc   = (bus.fetch_opcode != 3'd7) || (e_cond == bus.wait_pol);
    check("model_result", bus.result, e_res);
    check("model_wr_res", {7'b0, bus.wr_res}, {7'b0, e_wr});
    check("model_pattern_match", {7'b0, bus.pattern_match}, {7'b0, e_pm});
    check("model_pc_en", {7'b0, bus.pc_en}, {7'b0, e_pc});
  end

  task automatic step(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] im, input logic [2:0] fop,
                      input logic sel, input logic pol, input logic rdy);
    @(posedge clk); #1;
    bus.opcode = op; bus.rd_data_a = a; bus.rd_data_b = b; bus.imm = im;
    bus.fetch_opcode = fop; bus.wait_sel = sel; bus.wait_pol = pol; bus.ready_in = rdy;
    @(negedge clk);
  endtask

  initial begin
    n_reset = 1'b0;
    bus.opcode = 3'd0; bus.rd_data_a = 8'h00; bus.rd_data_b = 8'h00; bus.imm = 8'h00;
    bus.fetch_opcode = 3'd0; bus.wait_sel = 1'b0; bus.wait_pol = 1'b0; bus.ready_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", bus.result, 8'h00);
    check("reset_pattern_match", {7'b0, bus.pattern_match}, 8'h00);
    @(posedge clk); #1; n_reset = 1'b1;

    step(3'd0, 8'h11, 8'h22, 8'h33, 3'd0, 0, 0, 0);
    check("nop_result", bus.result, 8'h00);
    step(3'd1, 8'h00, 8'h00, 8'h5A, 3'd0, 0, 0, 0);
    check("ldi_wr_res", {7'b0, bus.wr_res}, 8'h01);
    step(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    check("ldi_result", bus.result, 8'h5A);
    step(3'd3, 8'hF0, 8'h20, 8'h00, 3'd0, 0, 0, 0);
    step(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    check("add_wrap_result", bus.result, 8'h10);
    step(3'd4, 8'h03, 8'hEE, 8'h04, 3'd0, 0, 0, 0);
    step(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    check("addi_result", bus.result, 8'h07);
    step(3'd5, 8'h00, 8'h33, 8'h00, 3'd0, 0, 0, 0);
    check("out_wr_res", {7'b0, bus.wr_res}, 8'h00);
    step(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    check("out_result", bus.result, 8'h33);
    step(3'd6, 8'h77, 8'h88, 8'h99, 3'd0, 0, 0, 0);
    check("clr_wr_res", {7'b0, bus.wr_res}, 8'h01);
    step(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    check("clr_result", bus.result, 8'h00);

    // WAIT on ready_in level
    step(3'd7, 8'h00, 8'h00, 8'h00, 3'd7, 0, 1, 0);
    check("wait_lvl_stall", {7'b0, bus.pc_en}, 8'h00);
    step(3'd7, 8'h00, 8'h00, 8'h00, 3'd7, 0, 1, 1);
    check("wait_lvl_release", {7'b0, bus.pc_en}, 8'h01);
    // WAIT on rising edge: level alone must not release
    step(3'd7, 8'h00, 8'h00, 8'h00, 3'd7, 1, 1, 1);
    check("wait_edge_held_hi", {7'b0, bus.pc_en}, 8'h00);
    step(3'd7, 8'h00, 8'h00, 8'h00, 3'd7, 1, 1, 0);
    check("wait_edge_low", {7'b0, bus.pc_en}, 8'h00);
    step(3'd7, 8'h00, 8'h00, 8'h00, 3'd7, 1, 1, 1);
    check("wait_edge_rise_pc", {7'b0, bus.pc_en}, 8'h01);
    check("wait_edge_rise_pm", {7'b0, bus.pattern_match}, 8'h01);
    step(3'd7, 8'h00, 8'h00, 8'h00, 3'd7, 1, 1, 1);
    check("wait_edge_one_shot", {7'b0, bus.pc_en}, 8'h00);
    step(3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 1, 1, 1);
    check("nonwait_advances", {7'b0, bus.pc_en}, 8'h01);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      n_reset          = 1'b1;
      bus.opcode       = 3'($urandom_range(0, 7));
      bus.rd_data_a    = 8'($urandom);
      bus.rd_data_b    = 8'($urandom);
      bus.imm          = 8'($urandom);
      bus.fetch_opcode = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      bus.wait_sel     = 1'($urandom);
      bus.wait_pol     = 1'($urandom);
      bus.ready_in     = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 n_reset = 1'b0;
      end
    end
    @(posedge clk); #1; n_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
